// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave memory window with independent read/write FSMs,
// programmable read latency, byte strobes and transaction counters.
module axi_lite_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    output logic [1:0]              b_resp_o,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [31:0]             wr_count_o,
    output logic [31:0]             rd_count_o
);
    localparam int unsigned NB = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(MEM_WORDS * NB);
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IDX_W'(off >> OFF_W);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    wstate_e               w_state_q, w_state_d;
    logic                  aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NB-1:0]         w_strb_q, w_strb_d;
    logic [1:0]            b_resp_q, b_resp_d;
    logic [31:0]           wr_cnt_q, wr_cnt_d;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [DATA_WIDTH-1:0] eff_data;
    logic [NB-1:0]         eff_strb;

    rstate_e               r_state_q, r_state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic [1:0]            r_resp_q, r_resp_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d;
    logic                  sample;
    logic [ADDR_WIDTH-1:0] samp_addr;

    // A channel captured this cycle bypasses its holding register.
    assign eff_addr = aw_cap_q ? aw_addr_q : aw_addr_i;
    assign eff_data = w_cap_q ? w_data_q : w_data_i;
    assign eff_strb = w_cap_q ? w_strb_q : w_strb_i;

    always_comb begin
        w_state_d = w_state_q;
        aw_cap_d = aw_cap_q;
        w_cap_d = w_cap_q;
        aw_addr_d = aw_addr_q;
        w_data_d = w_data_q;
        w_strb_d = w_strb_q;
        b_resp_d = b_resp_q;
        wr_cnt_d = wr_cnt_q;
        aw_ready_o = 1'b0;
        w_ready_o = 1'b0;
        mem_we = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                aw_ready_o = !aw_cap_q;
                w_ready_o = !w_cap_q;
                if (aw_valid_i && !aw_cap_q) begin
                    aw_cap_d = 1'b1;
                    aw_addr_d = aw_addr_i;
                end
                if (w_valid_i && !w_cap_q) begin
                    w_cap_d = 1'b1;
                    w_data_d = w_data_i;
                    w_strb_d = w_strb_i;
                end
                if (aw_cap_d && w_cap_d) begin
                    mem_we = in_range(eff_addr);
                    b_resp_d = mem_we ? OKAY : SLVERR;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    aw_cap_d = 1'b0;
                    w_cap_d = 1'b0;
                    wr_cnt_d = wr_cnt_q + 32'd1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            aw_cap_q <= 1'b0;
            w_cap_q <= 1'b0;
            aw_addr_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            b_resp_q <= 2'b00;
            wr_cnt_q <= 32'd0;
        end else begin
            w_state_q <= w_state_d;
            aw_cap_q <= aw_cap_d;
            w_cap_q <= w_cap_d;
            aw_addr_q <= aw_addr_d;
            w_data_q <= w_data_d;
            w_strb_q <= w_strb_d;
            b_resp_q <= b_resp_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (eff_strb[b]) mem_q[idx_of(eff_addr)][b*8 +: 8] <= eff_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        cnt_d = cnt_q;
        r_addr_d = r_addr_q;
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        rd_cnt_d = rd_cnt_q;
        ar_ready_o = 1'b0;
        sample = 1'b0;
        samp_addr = r_addr_q;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready_o = 1'b1;
                if (ar_valid_i) begin
                    r_addr_d = ar_addr_i;
                    cnt_d = CNT_W'(READ_LATENCY - 1);
                    if (cnt_d == '0) begin
                        sample = 1'b1;
                        samp_addr = ar_addr_i;
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    sample = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (r_ready_i) begin
                    rd_cnt_d = rd_cnt_q + 32'd1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        // Array read sees pre-edge contents, so a same-cycle commit returns old data.
        if (sample) begin
            if (in_range(samp_addr)) begin
                r_data_d = mem_q[idx_of(samp_addr)];
                r_resp_d = OKAY;
            end else begin
                r_data_d = '0;
                r_resp_d = SLVERR;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            cnt_q <= '0;
            r_addr_q <= '0;
            r_data_q <= '0;
            r_resp_q <= 2'b00;
            rd_cnt_q <= 32'd0;
        end else begin
            r_state_q <= r_state_d;
            cnt_q <= cnt_d;
            r_addr_q <= r_addr_d;
            r_data_q <= r_data_d;
            r_resp_q <= r_resp_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign b_valid_o = (w_state_q == W_RESP);
    assign b_resp_o = b_resp_q;
    assign r_valid_o = (r_state_q == R_RESP);
    assign r_data_o = r_data_q;
    assign r_resp_o = r_resp_q;
    assign wr_count_o = wr_cnt_q;
    assign rd_count_o = rd_cnt_q;
endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Scoreboard bench: two responders (read latency 1 and 4) driven by
// directed AXI-Lite transactions; monitors check B/R against queued expectations.
module tb_axi_lite_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [31:0] aw_addr [2];
    logic [31:0] ar_addr [2];
    logic        aw_valid [2];
    logic        w_valid [2];
    logic        ar_valid [2];
    logic        b_ready [2];
    logic        r_ready [2];
    logic [63:0] w_data [2];
    logic [7:0]  w_strb [2];
    logic        aw_ready [2];
    logic        w_ready [2];
    logic        b_valid [2];
    logic        ar_ready [2];
    logic        r_valid [2];
    logic [1:0]  b_resp [2];
    logic [1:0]  r_resp [2];
    logic [63:0] r_data [2];
    logic [31:0] wr_cnt [2];
    logic [31:0] rd_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_lite_mem_responder #(
            .READ_LATENCY(g == 0 ? 1 : 4)
        ) u_dut (
            .clk_i(clk),
            .rst_ni(rst_n),
            .aw_addr_i(aw_addr[g]),
            .aw_valid_i(aw_valid[g]),
            .aw_ready_o(aw_ready[g]),
            .w_data_i(w_data[g]),
            .w_strb_i(w_strb[g]),
            .w_valid_i(w_valid[g]),
            .w_ready_o(w_ready[g]),
            .b_resp_o(b_resp[g]),
            .b_valid_o(b_valid[g]),
            .b_ready_i(b_ready[g]),
            .ar_addr_i(ar_addr[g]),
            .ar_valid_i(ar_valid[g]),
            .ar_ready_o(ar_ready[g]),
            .r_data_o(r_data[g]),
            .r_resp_o(r_resp[g]),
            .r_valid_o(r_valid[g]),
            .r_ready_i(r_ready[g]),
            .wr_count_o(wr_cnt[g]),
            .rd_count_o(rd_cnt[g])
        );
    end

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [31:0] A1 = 32'h8000_0008;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;

    exp_t qb0[$];
    exp_t qb1[$];
    exp_t qr0[$];
    exp_t qr1[$];
    exp_t cur_b [2];
    exp_t cur_r [2];
    bit   busy_b [2];
    bit   busy_r [2];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                busy_b[g] = 1'b0;
                busy_r[g] = 1'b0;
            end else begin
                if (b_valid[g]) begin
                    if (!busy_b[g]) begin
                        if ((g == 0 ? qb0.size() : qb1.size()) == 0) begin
                            fail("b_unexpected");
                        end else begin
                            if (g == 0) cur_b[g] = qb0.pop_front();
                            else cur_b[g] = qb1.pop_front();
                            chk("b_latency", 64'(cyc), 64'(cur_b[g].cyc));
                            chk("b_resp", 64'(b_resp[g]), 64'(cur_b[g].resp));
                        end
                        busy_b[g] = 1'b1;
                    end else begin
                        chk("b_resp_hold", 64'(b_resp[g]), 64'(cur_b[g].resp));
                    end
                    if (b_ready[g]) busy_b[g] = 1'b0;
                end
                if (r_valid[g]) begin
                    if (!busy_r[g]) begin
                        if ((g == 0 ? qr0.size() : qr1.size()) == 0) begin
                            fail("r_unexpected");
                        end else begin
                            if (g == 0) cur_r[g] = qr0.pop_front();
                            else cur_r[g] = qr1.pop_front();
                            chk("r_latency", 64'(cyc), 64'(cur_r[g].cyc));
                            chk("r_data", r_data[g], cur_r[g].data);
                            chk("r_resp", 64'(r_resp[g]), 64'(cur_r[g].resp));
                        end
                        busy_r[g] = 1'b1;
                    end else begin
                        chk("r_data_hold", r_data[g], cur_r[g].data);
                        chk("r_resp_hold", 64'(r_resp[g]), 64'(cur_r[g].resp));
                    end
                    if (r_ready[g]) busy_r[g] = 1'b0;
                end
            end
        end
    end

    task automatic do_write(input int d, input logic [31:0] a, input logic [63:0] dat,
                            input logic [7:0] s, input int gap, input logic [1:0] rsp);
        exp_t e;
        bit ok;
        @(posedge clk); #1;
        w_data[d] = dat;
        w_strb[d] = s;
        w_valid[d] = 1'b1;
        if (gap == 0) begin
            aw_addr[d] = a;
            aw_valid[d] = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = w_ready[d] && (gap > 0 || aw_ready[d]);
        end
        if (!ok) fail("wr_handshake_timeout");
        if (gap > 0) begin
            @(posedge clk); #1;
            w_valid[d] = 1'b0;
            for (int i = 1; i < gap; i++) begin
                @(negedge clk);
                chk("w_ready_low", 64'(w_ready[d]), 64'd0);
                @(posedge clk); #1;
            end
            aw_addr[d] = a;
            aw_valid[d] = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                ok = aw_ready[d];
            end
            if (!ok) fail("aw_handshake_timeout");
            chk("w_ready_low", 64'(w_ready[d]), 64'd0);
        end
        e.data = '0;
        e.resp = rsp;
        e.cyc = cyc + 1;
        if (d == 0) qb0.push_back(e);
        else qb1.push_back(e);
        @(posedge clk); #1;
        aw_valid[d] = 1'b0;
        w_valid[d] = 1'b0;
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input logic [63:0] dat,
                           input logic [1:0] rsp);
        exp_t e;
        bit ok;
        @(posedge clk); #1;
        ar_addr[d] = a;
        ar_valid[d] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = ar_ready[d];
        end
        if (!ok) fail("ar_handshake_timeout");
        e.data = dat;
        e.resp = rsp;
        e.cyc = cyc + (d == 0 ? 1 : 4);
        if (d == 0) qr0.push_back(e);
        else qr1.push_back(e);
        @(posedge clk); #1;
        ar_valid[d] = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = qb0.size() == 0 && qb1.size() == 0 && qr0.size() == 0 &&
                   qr1.size() == 0 && !busy_b[0] && !busy_b[1] && !busy_r[0] && !busy_r[1];
        end
        if (!done) fail("drain_timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            aw_addr[d] = '0;
            ar_addr[d] = '0;
            aw_valid[d] = 1'b0;
            w_valid[d] = 1'b0;
            ar_valid[d] = 1'b0;
            w_data[d] = '0;
            w_strb[d] = '0;
            b_ready[d] = 1'b1;
            r_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_b_valid", 64'(b_valid[d]), 64'd0);
            chk("rst_r_valid", 64'(r_valid[d]), 64'd0);
            chk("rst_b_resp", 64'(b_resp[d]), 64'd0);
            chk("rst_r_resp", 64'(r_resp[d]), 64'd0);
            chk("rst_r_data", r_data[d], 64'd0);
            chk("rst_wr_cnt", 64'(wr_cnt[d]), 64'd0);
            chk("rst_rd_cnt", 64'(rd_cnt[d]), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_write(0, A1, 64'h1122334455667788, 8'hFF, 0, OKAY);
        drain();
        do_read(0, A1, 64'h1122334455667788, OKAY);
        drain();
        chk("wr_cnt_1", 64'(wr_cnt[0]), 64'd1);
        chk("rd_cnt_1", 64'(rd_cnt[0]), 64'd1);

        do_write(0, A1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 2, OKAY);
        drain();
        chk("w_ready_after_b", 64'(w_ready[0]), 64'd1);
        do_read(0, A1, 64'h1122_3344_FFFF_FFFF, OKAY);
        drain();

        do_write(0, 32'h8000_0000, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, 0, OKAY);
        drain();
        b_ready[0] = 1'b0;
        r_ready[0] = 1'b0;
        fork
            do_write(0, 32'h8000_0010, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, OKAY);
            do_read(0, A1, 64'h1122_3344_FFFF_FFFF, OKAY);
        join
        repeat (5) begin
            @(negedge clk);
            chk("stall_aw_ready", 64'(aw_ready[0]), 64'd0);
            chk("stall_w_ready", 64'(w_ready[0]), 64'd0);
            chk("stall_ar_ready", 64'(ar_ready[0]), 64'd0);
            chk("stall_b_valid", 64'(b_valid[0]), 64'd1);
            chk("stall_r_valid", 64'(r_valid[0]), 64'd1);
        end
        @(posedge clk); #1;
        b_ready[0] = 1'b1;
        r_ready[0] = 1'b1;
        drain();
        chk("wr_cnt_4", 64'(wr_cnt[0]), 64'd4);
        chk("rd_cnt_3", 64'(rd_cnt[0]), 64'd3);

        do_read(0, 32'h7FFF_FFF8, 64'd0, SLVERR);
        do_write(0, 32'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, SLVERR);
        drain();
        do_read(0, 32'h8000_0000, 64'hA5A5_5A5A_0F0F_F0F0, OKAY);
        do_write(0, 32'h8000_1FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, OKAY);
        do_read(0, 32'h8000_1FFC, 64'h0123_4567_89AB_CDEF, OKAY);
        do_read(0, 32'h8000_0010, 64'hCAFE_F00D_1234_5678, OKAY);
        drain();

        fork
            do_write(0, A1, 64'h0102_0304_0506_0708, 8'hFF, 0, OKAY);
            do_read(0, A1, 64'h1122_3344_FFFF_FFFF, OKAY);
        join
        drain();
        do_read(0, A1, 64'h0102_0304_0506_0708, OKAY);
        drain();

        do_write(1, 32'h8000_0020, 64'h1111_1111_1111_1111, 8'hFF, 0, OKAY);
        drain();
        fork
            do_write(1, 32'h8000_0020, 64'h2222_2222_2222_2222, 8'hFF, 0, OKAY);
            do_read(1, 32'h8000_0020, 64'h2222_2222_2222_2222, OKAY);
        join
        drain();
        chk("dut1_wr_cnt", 64'(wr_cnt[1]), 64'd2);
        chk("dut1_rd_cnt", 64'(rd_cnt[1]), 64'd1);

        b_ready[0] = 1'b0;
        do_write(0, 32'h8000_0030, 64'h3333_3333_3333_3333, 8'hFF, 0, OKAY);
        do_read(1, 32'h8000_0020, 64'h2222_2222_2222_2222, OKAY);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_b_valid", 64'(b_valid[0]), 64'd0);
        chk("arst_r_valid", 64'(r_valid[1]), 64'd0);
        chk("arst_wr_cnt0", 64'(wr_cnt[0]), 64'd0);
        chk("arst_rd_cnt0", 64'(rd_cnt[0]), 64'd0);
        chk("arst_wr_cnt1", 64'(wr_cnt[1]), 64'd0);
        chk("arst_rd_cnt1", 64'(rd_cnt[1]), 64'd0);
        qb0.delete();
        qb1.delete();
        qr0.delete();
        qr1.delete();
        b_ready[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_no_r_valid", 64'(r_valid[1]), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_write(0, 32'h8000_0030, 64'h4444_4444_4444_4444, 8'hFF, 0, OKAY);
        do_read(0, 32'h8000_0030, 64'h4444_4444_4444_4444, OKAY);
        do_read(1, 32'h8000_0020, 64'h2222_2222_2222_2222, OKAY);
        drain();
        chk("post_wr_cnt0", 64'(wr_cnt[0]), 64'd1);
        chk("post_rd_cnt0", 64'(rd_cnt[0]), 64'd1);
        chk("post_rd_cnt1", 64'(rd_cnt[1]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
